uart_rx_deframer: RTL and testbench



---
 rtl/uart_rx_deframer.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: mid-bit sampling of rxd, 1..16 data bits LSB first, optional parity,
// one or two stop bits, AXI-Stream output with error flags. Optional macro: UART_RX_GLITCH_FILTER_EN.
module uart_rx_deframer #(
  parameter int BAUD_PRESCALER = 12,
  parameter int PARITY         = 0,
  parameter int BYTE_SIZE      = 8,
  parameter int STOP_BITS      = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [26:0] s_axis_config_tdata,
  input  logic        s_axis_config_tvalid,
  output logic        s_axis_config_tready,
  output logic [15:0] m_axis_tdata,
  output logic [2:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        rxd,
  output logic        rtsn
);

  // Handshakes: a config word transfers on a cycle where s_axis_config_tvalid and
  // s_axis_config_tready are both high; an output beat transfers on a cycle where
  // m_axis_tvalid and m_axis_tready are both high; tdata/tuser hold while valid && !ready.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_STOP2 = 3'd5;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam logic [15:0] MIN_PRESC = 16'd4;
`else
  localparam logic [15:0] MIN_PRESC = 16'd2;
`endif

  localparam logic [15:0] RST_PRESC  = 16'(BAUD_PRESCALER);
  localparam logic [2:0]  RST_PARITY = 3'(PARITY);
  localparam logic [3:0]  RST_BSIZE  = 4'(BYTE_SIZE);
  localparam logic        RST_STOP   = (STOP_BITS != 0);

  logic [2:0]  state;
  logic [15:0] cfg_presc;
  logic [2:0]  cfg_parity;
  logic [3:0]  cfg_bsize;
  logic        cfg_stop;
  logic        cfg_rx_en;

  logic        rxd_m, rxd_q, rxd_prev;
  logic        rxd_s;
  logic [15:0] baud_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] data;
  logic        par_acc, par_err, frm_err, ovr_pend;

  logic [15:0] presc_eff;
  logic [4:0]  last_bit;
  logic        par_en, par_exp, cfg_hs, tick, fall, out_free, commit, frm_final;
  logic        unused_cfg;

  assign unused_cfg = ^{s_axis_config_tdata[26], s_axis_config_tdata[24]};

`ifdef UART_RX_GLITCH_FILTER_EN
  logic rxd_h1, rxd_h2;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rxd_h1 <= 1'b1;
      rxd_h2 <= 1'b1;
    end else begin
      rxd_h1 <= rxd_q;
      rxd_h2 <= rxd_h1;
    end
  end
  assign rxd_s = (rxd_q & rxd_h1) | (rxd_q & rxd_h2) | (rxd_h1 & rxd_h2);
`else
  assign rxd_s = rxd_q;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rxd_m    <= 1'b1;
      rxd_q    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_m    <= rxd;
      rxd_q    <= rxd_m;
      rxd_prev <= rxd_s;
    end
  end

  assign presc_eff = (cfg_presc < MIN_PRESC) ? MIN_PRESC : cfg_presc;
  assign last_bit  = (cfg_bsize == 4'd0) ? 5'd15 : ({1'b0, cfg_bsize} - 5'd1);
  assign par_en    = (cfg_parity != 3'd0) && (cfg_parity <= 3'd4);
  assign cfg_hs    = s_axis_config_tvalid && s_axis_config_tready;
  assign tick      = (baud_cnt == 16'd0);
  assign fall      = rxd_prev & ~rxd_s;
  assign out_free  = ~m_axis_tvalid | m_axis_tready;
  assign commit    = tick && (((state == S_STOP) && !cfg_stop) || (state == S_STOP2));
  assign frm_final = frm_err | ~rxd_s;

  always_comb begin
    par_exp = 1'b0;
    case (cfg_parity)
      3'd1:    par_exp = par_acc;
      3'd2:    par_exp = ~par_acc;
      3'd3:    par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  assign s_axis_config_tready = (state == S_IDLE);
  assign rtsn = ~aresetn | ~(cfg_rx_en & ~m_axis_tvalid);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      cfg_presc     <= RST_PRESC;
      cfg_parity    <= RST_PARITY;
      cfg_bsize     <= RST_BSIZE;
      cfg_stop      <= RST_STOP;
      cfg_rx_en     <= 1'b1;
      baud_cnt      <= 16'd0;
      bit_cnt       <= 5'd0;
      data          <= 16'd0;
      par_acc       <= 1'b0;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      ovr_pend      <= 1'b0;
      m_axis_tdata  <= 16'd0;
      m_axis_tuser  <= 3'd0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_hs) begin
            cfg_presc  <= s_axis_config_tdata[15:0];
            cfg_parity <= s_axis_config_tdata[18:16];
            cfg_bsize  <= s_axis_config_tdata[22:19];
            cfg_stop   <= s_axis_config_tdata[23];
            cfg_rx_en  <= s_axis_config_tdata[25];
          end else if (cfg_rx_en && fall) begin
            baud_cnt <= presc_eff >> 1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (!tick) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else if (rxd_s) begin
            state <= S_IDLE;
          end else begin
            baud_cnt <= presc_eff - 16'd1;
            bit_cnt  <= 5'd0;
            data     <= 16'd0;
            par_acc  <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (!tick) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            data[bit_cnt[3:0]] <= rxd_s;
            par_acc  <= par_acc ^ rxd_s;
            baud_cnt <= presc_eff - 16'd1;
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == last_bit)
              state <= par_en ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (!tick) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            if (rxd_s != par_exp)
              par_err <= 1'b1;
            baud_cnt <= presc_eff - 16'd1;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (!tick) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else if (cfg_stop) begin
            frm_err  <= frm_final;
            baud_cnt <= presc_eff - 16'd1;
            state    <= S_STOP2;
          end else begin
            state <= S_IDLE;
          end
        end
        S_STOP2: begin
          if (!tick)
            baud_cnt <= baud_cnt - 16'd1;
          else
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Returning to IDLE at mid-stop leaves half a bit to resync on the next start edge.
      if (commit) begin
        if (out_free) begin
          m_axis_tdata  <= data;
          m_axis_tuser  <= {ovr_pend, frm_final, par_err};
          m_axis_tvalid <= 1'b1;
          ovr_pend      <= 1'b0;
        end else begin
          ovr_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: serial frames driven on rxd, beats checked
// against an expected queue filled as each frame is sent.
module tb_uart_rx_deframer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [26:0] cfg_tdata = '0;
  logic        cfg_tvalid = 1'b0;
  logic        cfg_tready;
  logic [15:0] m_tdata;
  logic [2:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        rxd = 1'b1;
  logic        rtsn;

  logic [18:0] exp_q[$];
  logic [18:0] mon_exp;
  int checks = 0;
  int errors = 0;
  int beats  = 0;

  uart_rx_deframer dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_config_tdata  (cfg_tdata),
    .s_axis_config_tvalid (cfg_tvalid),
    .s_axis_config_tready (cfg_tready),
    .m_axis_tdata         (m_tdata),
    .m_axis_tuser         (m_tuser),
    .m_axis_tvalid        (m_tvalid),
    .m_axis_tready        (m_tready),
    .rxd                  (rxd),
    .rtsn                 (rtsn)
  );

  always #5 aclk = ~aclk;

  // Output monitor: every accepted beat must match the head of the expected queue.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got tdata=%h tuser=%b", m_tdata, m_tuser);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_tuser, m_tdata} !== mon_exp) begin
          errors++;
          $display("FAIL beat got tuser=%b tdata=%h want tuser=%b tdata=%h",
                   m_tuser, m_tdata, mon_exp[18:16], mon_exp[15:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] d, input int nb, input int par, input int sb,
                            input int presc, input bit flip_par, input bit stop_val);
    logic x;
    logic pb;
    x = 1'b0;
    rxd = 1'b0;
    tick(presc);
    for (int i = 0; i < nb; i++) begin
      rxd = d[i];
      x = x ^ d[i];
      tick(presc);
    end
    if (par >= 1 && par <= 4) begin
      case (par)
        1: pb = x;
        2: pb = ~x;
        3: pb = 1'b1;
        default: pb = 1'b0;
      endcase
      rxd = pb ^ flip_par;
      tick(presc);
    end
    rxd = stop_val;
    tick(presc);
    if (sb != 0) tick(presc);
  endtask

  task automatic cfg_write(input logic [15:0] presc, input logic [2:0] par, input logic [3:0] bs,
                           input logic sb, input logic en);
    int k;
    cfg_tdata  = {1'b0, en, 1'b0, sb, bs, par, presc};
    cfg_tvalid = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (cfg_tready) break;
      tick(1);
    end
    checks++;
    if (!cfg_tready) begin
      errors++;
      $display("FAIL cfg_handshake got tready=%b want 1", cfg_tready);
    end
    tick(1);
    cfg_tvalid = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 4000; k++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(3);
    checks++;
    if ({rtsn, m_tvalid, m_tuser, m_tdata} !== {1'b1, 1'b0, 3'b000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_outputs got rtsn=%b tvalid=%b tuser=%b tdata=%h want 1 0 000 0000",
               rtsn, m_tvalid, m_tuser, m_tdata);
    end
    aresetn = 1'b1;
    tick(2);
    checks++;
    if ({rtsn, cfg_tready} !== 2'b01) begin
      errors++;
      $display("FAIL after_reset got rtsn=%b cfg_tready=%b want 0 1", rtsn, cfg_tready);
    end
  endtask

  task automatic test_basic();
    m_tready = 1'b0;
    exp_q.push_back({3'b000, 16'h00A5});
    send_frame(16'h00A5, 8, 0, 0, 12, 1'b0, 1'b1);
    checks++;
    if ({m_tvalid, rtsn, m_tdata} !== {1'b1, 1'b1, 16'h00A5}) begin
      errors++;
      $display("FAIL basic_valid got tvalid=%b rtsn=%b tdata=%h want 1 1 00a5", m_tvalid, rtsn, m_tdata);
    end
    tick(24);
    checks++;
    if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 3'b000, 16'h00A5}) begin
      errors++;
      $display("FAIL basic_hold got tvalid=%b tuser=%b tdata=%h want 1 000 00a5", m_tvalid, m_tuser, m_tdata);
    end
    m_tready = 1'b1;
    wait_drain();
    tick(1);
    checks++;
    if ({m_tvalid, rtsn} !== 2'b00) begin
      errors++;
      $display("FAIL basic_release got tvalid=%b rtsn=%b want 0 0", m_tvalid, rtsn);
    end
  endtask

  task automatic test_parity();
    cfg_write(16'd16, 3'd1, 4'd7, 1'b0, 1'b1);
    exp_q.push_back({3'b001, 16'h0035});
    send_frame(16'h0035, 7, 1, 0, 16, 1'b1, 1'b1);
    tick(32);
    exp_q.push_back({3'b000, 16'h0035});
    send_frame(16'h0035, 7, 1, 0, 16, 1'b0, 1'b1);
    tick(32);
    cfg_write(16'd16, 3'd2, 4'd0, 1'b0, 1'b1);
    exp_q.push_back({3'b000, 16'hBEEF});
    send_frame(16'hBEEF, 16, 2, 0, 16, 1'b0, 1'b1);
    tick(32);
    exp_q.push_back({3'b001, 16'h1234});
    send_frame(16'h1234, 16, 2, 0, 16, 1'b1, 1'b1);
    tick(32);
    wait_drain();
    cfg_write(16'd12, 3'd0, 4'd8, 1'b0, 1'b1);
  endtask

  task automatic test_stop_low();
    int b0;
    b0 = beats;
    exp_q.push_back({3'b010, 16'h003C});
    send_frame(16'h003C, 8, 0, 0, 12, 1'b0, 1'b0);
    tick(12 * 30);
    checks++;
    if (beats !== b0 + 1) begin
      errors++;
      $display("FAIL break_beats got %0d want %0d", beats - b0, 1);
    end
    rxd = 1'b1;
    tick(36);
    checks++;
    if ({beats == b0 + 1, cfg_tready} !== 2'b11) begin
      errors++;
      $display("FAIL break_release got beats=%0d cfg_tready=%b want 1 1", beats - b0, cfg_tready);
    end
    wait_drain();
  endtask

  task automatic test_glitch();
    int b0;
    b0 = beats;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(2);
    checks++;
    if (cfg_tready !== 1'b0) begin
      errors++;
      $display("FAIL glitch_start got cfg_tready=%b want 0", cfg_tready);
    end
    tick(30);
    checks++;
    if ({cfg_tready, m_tvalid, beats == b0} !== 3'b101) begin
      errors++;
      $display("FAIL glitch_idle got cfg_tready=%b tvalid=%b beats=%0d want 1 0 0",
               cfg_tready, m_tvalid, beats - b0);
    end
  endtask

  task automatic test_overrun();
    m_tready = 1'b0;
    exp_q.push_back({3'b000, 16'h0011});
    send_frame(16'h0011, 8, 0, 0, 12, 1'b0, 1'b1);
    tick(12);
    send_frame(16'h0022, 8, 0, 0, 12, 1'b0, 1'b1);
    tick(12);
    send_frame(16'h0033, 8, 0, 0, 12, 1'b0, 1'b1);
    tick(12);
    checks++;
    if ({m_tvalid, rtsn, m_tuser, m_tdata} !== {1'b1, 1'b1, 3'b000, 16'h0011}) begin
      errors++;
      $display("FAIL overrun_hold got tvalid=%b rtsn=%b tuser=%b tdata=%h want 1 1 000 0011",
               m_tvalid, rtsn, m_tuser, m_tdata);
    end
    m_tready = 1'b1;
    wait_drain();
    exp_q.push_back({3'b100, 16'h0044});
    send_frame(16'h0044, 8, 0, 0, 12, 1'b0, 1'b1);
    tick(24);
    wait_drain();
  endtask

  task automatic test_reset_midframe();
    int b0;
    cfg_write(16'd12, 3'd0, 4'd8, 1'b1, 1'b1);
    exp_q.push_back({3'b000, 16'h005A});
    send_frame(16'h005A, 8, 0, 1, 12, 1'b0, 1'b1);
    tick(12);
    wait_drain();
    b0 = beats;
    rxd = 1'b0; tick(12);
    rxd = 1'b1; tick(12);
    rxd = 1'b0; tick(12);
    rxd = 1'b1; tick(12);
    checks++;
    if (cfg_tready !== 1'b0) begin
      errors++;
      $display("FAIL midframe_busy got cfg_tready=%b want 0", cfg_tready);
    end
    aresetn = 1'b0;
    tick(1);
    checks++;
    if ({rtsn, m_tvalid} !== 2'b10) begin
      errors++;
      $display("FAIL midframe_in_reset got rtsn=%b tvalid=%b want 1 0", rtsn, m_tvalid);
    end
    tick(1);
    aresetn = 1'b1;
    tick(1);
    checks++;
    if ({cfg_tready, m_tvalid} !== 2'b10) begin
      errors++;
      $display("FAIL midframe_after_reset got cfg_tready=%b tvalid=%b want 1 0", cfg_tready, m_tvalid);
    end
    tick(12 * 12);
    checks++;
    if (beats !== b0) begin
      errors++;
      $display("FAIL midframe_no_beat got %0d want 0", beats - b0);
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_stop_low();
    test_glitch();
    test_overrun();
    test_parity();
    test_reset_midframe();
    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
